// File: rtl/tmds_encoder_pkg.sv
// Shared TMDS constants (control symbols, reset symbol, disparity width) and helpers
// used by the encoder top level and its per-channel encoder.
package tmds_encoder_pkg;

  localparam int CNT_W_DEF = 5;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] RESET_SYM_DEF = CTRL_00;

  // Stage-1 register contents: transition-minimised word plus what stage 2 needs
  typedef struct packed {
    logic [8:0] q_m;
    logic [3:0] n1;
    logic       blank;
    logic       c1;
    logic       c0;
  } stage1_t;

  localparam stage1_t S1_RESET = '{q_m: 9'd0, n1: 4'd0, blank: 1'b1, c1: 1'b0, c0: 1'b0};

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    logic [9:0] s;
    s = CTRL_00;
    case ({c1, c0})
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      2'b11:   s = CTRL_11;
      default: s = CTRL_00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_encoder_channel.sv
// tmds_channel: one DVI 1.0 TMDS channel, two-stage pipeline
// (transition minimisation, then DC balance with a per-channel running disparity).
module tmds_channel
  import tmds_encoder_pkg::*;
#(
  parameter int         CNT_W     = CNT_W_DEF,
  parameter logic [9:0] RESET_SYM = RESET_SYM_DEF
) (
  input  logic       I_CLK_VGA,
  input  logic       I_RESET,
  input  logic [7:0] I_DATA,
  input  logic       I_C0,
  input  logic       I_C1,
  input  logic       I_BLANK,
  output logic [9:0] O_SYM
);

  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] ZERO = '0;

  stage1_t s1_d, s1_q;
  logic [3:0] n1d;
  logic use_xnor;
  logic chain;
  logic signed [CNT_W-1:0] cnt, cnt_next, disp;
  logic [9:0] sym_next;

  // The XOR/XNOR chain is carried in a scalar so the loop never reads back its own output vector
  always_comb begin
    s1_d     = '0;
    n1d      = popcount8(I_DATA);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !I_DATA[0]);
    chain    = I_DATA[0];
    s1_d.q_m[0] = chain;
    for (int i = 1; i < 8; i++) begin
      chain       = use_xnor ? ~(chain ^ I_DATA[i]) : (chain ^ I_DATA[i]);
      s1_d.q_m[i] = chain;
    end
    s1_d.q_m[8] = ~use_xnor;
    s1_d.n1     = popcount8(s1_d.q_m[7:0]);
    s1_d.blank  = I_BLANK;
    s1_d.c1     = I_C1;
    s1_d.c0     = I_C0;
  end

  always_ff @(posedge I_CLK_VGA) begin
    if (I_RESET) s1_q <= S1_RESET;
    else         s1_q <= s1_d;
  end

  // disp is n1 - n0 of q_m[7:0], i.e. 2*n1 - 8
  always_comb begin
    disp     = CNT_W'({s1_q.n1, 1'b0}) - CNT_W'(8);
    sym_next = ctrl_sym(s1_q.c1, s1_q.c0);
    cnt_next = '0;
    if (!s1_q.blank) begin
      if ((cnt == ZERO) || (s1_q.n1 == 4'd4)) begin
        sym_next = {~s1_q.q_m[8], s1_q.q_m[8],
                    s1_q.q_m[8] ? s1_q.q_m[7:0] : ~s1_q.q_m[7:0]};
        cnt_next = s1_q.q_m[8] ? (cnt + disp) : (cnt - disp);
      end else if ((!cnt[CNT_W-1] && (s1_q.n1 > 4'd4)) ||
                   ( cnt[CNT_W-1] && (s1_q.n1 < 4'd4))) begin
        sym_next = {1'b1, s1_q.q_m[8], ~s1_q.q_m[7:0]};
        cnt_next = cnt + (s1_q.q_m[8] ? TWO : ZERO) - disp;
      end else begin
        sym_next = {1'b0, s1_q.q_m[8], s1_q.q_m[7:0]};
        cnt_next = cnt - (s1_q.q_m[8] ? ZERO : TWO) + disp;
      end
    end
  end

  always_ff @(posedge I_CLK_VGA) begin
    if (I_RESET) begin
      cnt   <= '0;
      O_SYM <= RESET_SYM;
    end else begin
      cnt   <= cnt_next;
      O_SYM <= sym_next;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: three-channel DVI 1.0 TMDS encoder for the NES VGA path.
// Define TMDS_OUT_REG_EN to add an output register (latency 3 instead of 2).
module tmds_encoder
  import tmds_encoder_pkg::*;
#(
  parameter int         CNT_W     = CNT_W_DEF,
  parameter logic [9:0] RESET_SYM = RESET_SYM_DEF
) (
  input  logic       I_CLK_VGA,
  input  logic       I_RESET,
  input  logic [7:0] I_RED,
  input  logic [7:0] I_GREEN,
  input  logic [7:0] I_BLUE,
  input  logic       I_HSYNC,
  input  logic       I_VSYNC,
  input  logic       I_BLANK,
  output logic [9:0] O_TMDS_R,
  output logic [9:0] O_TMDS_G,
  output logic [9:0] O_TMDS_B
);

  logic [9:0] sym_r, sym_g, sym_b;

  tmds_channel #(.CNT_W(CNT_W), .RESET_SYM(RESET_SYM)) u_red (
    .I_CLK_VGA(I_CLK_VGA), .I_RESET(I_RESET), .I_DATA(I_RED),
    .I_C0(1'b0), .I_C1(1'b0), .I_BLANK(I_BLANK), .O_SYM(sym_r)
  );

  tmds_channel #(.CNT_W(CNT_W), .RESET_SYM(RESET_SYM)) u_green (
    .I_CLK_VGA(I_CLK_VGA), .I_RESET(I_RESET), .I_DATA(I_GREEN),
    .I_C0(1'b0), .I_C1(1'b0), .I_BLANK(I_BLANK), .O_SYM(sym_g)
  );

  // Sync levels ride only on channel 0 as C1=VSYNC, C0=HSYNC
  tmds_channel #(.CNT_W(CNT_W), .RESET_SYM(RESET_SYM)) u_blue (
    .I_CLK_VGA(I_CLK_VGA), .I_RESET(I_RESET), .I_DATA(I_BLUE),
    .I_C0(I_HSYNC), .I_C1(I_VSYNC), .I_BLANK(I_BLANK), .O_SYM(sym_b)
  );

`ifdef TMDS_OUT_REG_EN
  always_ff @(posedge I_CLK_VGA) begin
    if (I_RESET) begin
      O_TMDS_R <= RESET_SYM;
      O_TMDS_G <= RESET_SYM;
      O_TMDS_B <= RESET_SYM;
    end else begin
      O_TMDS_R <= sym_r;
      O_TMDS_G <= sym_g;
      O_TMDS_B <= sym_b;
    end
  end
`else
  assign O_TMDS_R = sym_r;
  assign O_TMDS_G = sym_g;
  assign O_TMDS_B = sym_b;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed reset/sync/video cases, then random
// pixels against a DVI 1.0 reference model plus a symbol decoder.
module tb_tmds_encoder;

`ifdef TMDS_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [9:0] RST_SYM = 10'b1101010100;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic       hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
  logic [9:0] tmds_r, tmds_g, tmds_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .I_CLK_VGA(clk), .I_RESET(reset_i),
    .I_RED(red), .I_GREEN(green), .I_BLUE(blue),
    .I_HSYNC(hsync), .I_VSYNC(vsync), .I_BLANK(blank),
    .O_TMDS_R(tmds_r), .O_TMDS_G(tmds_g), .O_TMDS_B(tmds_b)
  );

  // index 0 = blue, 1 = green, 2 = red
  typedef struct {
    logic [2:0][9:0] sym;
    logic [2:0][7:0] data;
    bit              video;
    int              cnt_b;
    bit              has_want;
    logic [9:0]      want_b;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt[3];

  function automatic logic [9:0] ctrl_model(input logic c1, input logic c0);
    logic [9:0] s;
    case ({c1, c0})
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] encode_pixel(input logic [7:0] d, input int cnt_in,
                                              output int cnt_out);
    int n1d, n1, n0;
    bit xn;
    logic [8:0] qm;
    logic [9:0] s;
    n1d = 0;
    for (int i = 0; i < 8; i++) n1d += int'(d[i]);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * int'(qm[8]) + n0 - n1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (qm[8] ? 0 : 1) + n1 - n0;
    end
    return s;
  endfunction

  function automatic logic [7:0] decode_sym(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic check_output(input exp_t e);
    logic [2:0][9:0] obs;
    int c;
    obs = {tmds_r, tmds_g, tmds_b};
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      assert (obs[ch] === e.sym[ch]) else begin
        failures++;
        $error("[TB] FAIL sym_ch%0d: got %b expected %b", ch, obs[ch], e.sym[ch]);
      end
      if (e.video) begin
        checks++;
        assert (decode_sym(obs[ch]) === e.data[ch]) else begin
          failures++;
          $error("[TB] FAIL decode_ch%0d: got %h expected %h", ch, decode_sym(obs[ch]), e.data[ch]);
        end
      end
    end
    if (e.has_want) begin
      checks++;
      assert (tmds_b === e.want_b) else begin
        failures++;
        $error("[TB] FAIL directed_blue: got %b expected %b", tmds_b, e.want_b);
      end
    end
    c = int'($signed(dut.u_blue.cnt));
    checks++;
    assert (c >= -10 && c <= 10) else begin
      failures++;
      $error("[TB] FAIL cnt_bound: got %0d expected |cnt|<=10", c);
    end
`ifndef TMDS_OUT_REG_EN
    checks++;
    assert (c === e.cnt_b) else begin
      failures++;
      $error("[TB] FAIL cnt_blue: got %0d expected %0d", c, e.cnt_b);
    end
`endif
  endtask

  task automatic apply_stimulus(input logic rst, input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input logic hs, input logic vs,
                                input logic bl, input bit has_want, input logic [9:0] want_b);
    exp_t e;
    logic [2:0][7:0] d;
    int nc;
    reset_i = rst; red = r; green = g; blue = b; hsync = hs; vsync = vs; blank = bl;
    d = {r, g, b};
    if (rst) begin
      exp_q.delete();
      for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
      e.sym = {RST_SYM, RST_SYM, RST_SYM};
      e.data = '0; e.video = 1'b0; e.cnt_b = 0; e.has_want = 1'b0; e.want_b = '0;
      for (int k = 0; k < LAT; k++) exp_q.push_back(e);
    end else begin
      e.data = d; e.has_want = has_want; e.want_b = want_b;
      if (bl) begin
        e.sym[0] = ctrl_model(vs, hs);
        e.sym[1] = ctrl_model(1'b0, 1'b0);
        e.sym[2] = ctrl_model(1'b0, 1'b0);
        for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
        e.video = 1'b0;
      end else begin
        for (int ch = 0; ch < 3; ch++) begin
          e.sym[ch] = encode_pixel(d[ch], mcnt[ch], nc);
          mcnt[ch] = nc;
        end
        e.video = 1'b1;
      end
      e.cnt_b = mcnt[0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        int c;
        case (ch)
          0:       c = int'($signed(dut.u_blue.cnt));
          1:       c = int'($signed(dut.u_green.cnt));
          default: c = int'($signed(dut.u_red.cnt));
        endcase
        checks++;
        assert (c === 0) else begin
          failures++;
          $error("[TB] FAIL reset_cnt_ch%0d: got %0d expected 0", ch, c);
        end
      end
    end
    if (exp_q.size() >= LAT) check_output(exp_q.pop_front());
  endtask

  initial begin
    @(negedge clk);

    // reset held for three clocks
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0, '0);

    // all four blue control codes
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1, 10'b0101010100);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 10'b1101010100);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 10'b0010101011);
    apply_stimulus(0, 0, 0, 0, 1, 1, 1, 1, 10'b1010101011);

    // 0x00 after blank, then a mid-video reset with nonzero disparity
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 1, 10'b0100000000);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 1, 10'b1111111111);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 8'h00, 0, 0, 0, 1, RST_SYM);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 1, 10'b0100000000);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);

    // 0xFF, one blank clock, 0xFF again
    apply_stimulus(0, 0, 0, 8'hFF, 0, 0, 0, 1, 10'b1000000000);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);
    apply_stimulus(0, 0, 0, 8'hFF, 0, 0, 0, 1, 10'b1000000000);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);

    // random pixels with occasional blanking and rare resets
    for (int i = 0; i < 10000; i++) begin
      apply_stimulus(($urandom_range(0, 499) == 0),
                     8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), 1'($urandom),
                     ($urandom_range(0, 15) == 0), 0, '0);
    end

    for (int i = 0; i < LAT; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
